instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/instr_encoder_loader.sv | 103 ++++++++++
 tb/tb_instr_encoder_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes LEGv8-style instruction requests into 32-bit words, queues them in a
// 4-deep FIFO and streams them into instruction memory at an auto-incrementing address.
module instr_encoder_loader (
   input  logic        CLK,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [25:0] imm,
   input  logic [1:0]  hw,
   input  logic        load_base,
   input  logic [31:0] base_addr,
   input  logic        mem_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        err,
   output logic        busy,
   output logic [15:0] words_written
);

   logic [31:0] fifo_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic [31:0] write_addr;
   logic [31:0] enc_word;
   logic        legal;
   logic        accept;
   logic        push;
   logic        pop;

   always_comb begin
      enc_word = '0;
      legal    = 1'b1;
      case (op)
         4'd0:    enc_word = {11'b10001010000, rm, 6'b0, rn, rd};
         4'd1:    enc_word = {11'b10101010000, rm, 6'b0, rn, rd};
         4'd2:    enc_word = {11'b10001011000, rm, 6'b0, rn, rd};
         4'd3:    enc_word = {11'b11001011000, rm, 6'b0, rn, rd};
         4'd4:    enc_word = {10'b1001000100, imm[11:0], rn, rd};
         4'd5:    enc_word = {10'b1101000100, imm[11:0], rn, rd};
         4'd6:    enc_word = {9'b110100101, hw, imm[15:0], rd};
         4'd7:    enc_word = {6'b000101, imm[25:0]};
         4'd8:    enc_word = {8'b10110100, imm[18:0], rd};
         4'd9:    enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
         4'd10:   enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
         default: legal    = 1'b0;
      endcase
   end

   // Readiness depends only on occupancy, so a full FIFO refuses even while popping.
   assign in_ready   = (count < 3'd4);
   assign busy       = (count != 3'd0);
   assign imem_we    = busy;
   assign imem_addr  = write_addr;
   assign imem_wdata = busy ? fifo_mem[rd_ptr] : 32'h0;

   assign accept = in_valid & in_ready;
   assign push   = accept & legal;
   assign pop    = busy & mem_ready;

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= enc_word;
      end
   end

   // load_base wins over the increment; a write completing on that edge already used the old address.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr        <= 2'd0;
         rd_ptr        <= 2'd0;
         count         <= 3'd0;
         write_addr    <= 32'h0;
         words_written <= 16'h0;
         err           <= 1'b0;
      end else begin
         err <= accept & ~legal;
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr        <= rd_ptr + 2'd1;
            words_written <= words_written + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (load_base) begin
            write_addr <= base_addr;
         end else if (pop) begin
            write_addr <= write_addr + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all compared every cycle against a queue-based behavioural model.
module tb_instr_encoder_loader;

   logic        CLK = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [4:0]  rd;
   logic [4:0]  rn;
   logic [4:0]  rm;
   logic [25:0] imm;
   logic [1:0]  hw;
   logic        load_base;
   logic [31:0] base_addr;
   logic        mem_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        err;
   logic        busy;
   logic [15:0] words_written;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_q[$];
   logic [31:0] mdl_addr  = 32'h0;
   logic [15:0] mdl_words = 16'h0;
   logic        mdl_err   = 1'b0;
   logic        mdl_fresh = 1'b1;
   logic        mdl_pop;
   logic        mdl_acc;

   instr_encoder_loader dut (
      .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .hw(hw),
      .load_base(load_base), .base_addr(base_addr), .mem_ready(mem_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .err(err), .busy(busy), .words_written(words_written)
   );

   always #5 CLK = ~CLK;

   // Reference encoding: opcode base value plus each field scaled to its bit position.
   function automatic logic [31:0] refEncode(input logic [3:0] o, input logic [4:0] d,
                                             input logic [4:0] n, input logic [4:0] m,
                                             input logic [25:0] im, input logic [1:0] h);
      logic [31:0] r;
      logic [31:0] dv;
      logic [31:0] nv;
      logic [31:0] mv;
      logic [31:0] iv;
      dv = 32'(d);
      nv = 32'(n) * 32;
      mv = 32'(m) * 65536;
      iv = 32'(im);
      case (o)
         4'd0:    r = 32'h8A000000 + mv + nv + dv;
         4'd1:    r = 32'hAA000000 + mv + nv + dv;
         4'd2:    r = 32'h8B000000 + mv + nv + dv;
         4'd3:    r = 32'hCB000000 + mv + nv + dv;
         4'd4:    r = 32'h91000000 + (iv % 4096) * 1024 + nv + dv;
         4'd5:    r = 32'hD1000000 + (iv % 4096) * 1024 + nv + dv;
         4'd6:    r = 32'hD2800000 + 32'(h) * 2097152 + (iv % 65536) * 32 + dv;
         4'd7:    r = 32'h14000000 + iv;
         4'd8:    r = 32'hB4000000 + (iv % 524288) * 32 + dv;
         4'd9:    r = 32'hF8400000 + (iv % 512) * 4096 + nv + dv;
         default: r = 32'hF8000000 + (iv % 512) * 4096 + nv + dv;
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [4:0] d,
                                input logic [4:0] n, input logic [4:0] m, input logic [25:0] im,
                                input logic [1:0] h, input logic lb, input logic [31:0] ba,
                                input logic mr);
      in_valid  = v;
      op        = o;
      rd        = d;
      rn        = n;
      rm        = m;
      imm       = im;
      hw        = h;
      load_base = lb;
      base_addr = ba;
      mem_ready = mr;
   endtask

   task automatic idle(input logic mr);
      applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b0, 32'h0, mr);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Model state advances on each rising edge from the inputs presented before it.
   always @(posedge CLK or posedge reset) begin
      if (reset) begin
         mdl_q.delete();
         mdl_addr  = 32'h0;
         mdl_words = 16'h0;
         mdl_err   = 1'b0;
         mdl_fresh = 1'b1;
      end else begin
         mdl_pop = (mdl_q.size() > 0) && mem_ready;
         mdl_acc = in_valid && (mdl_q.size() < 4);
         mdl_err = mdl_acc && (op > 4'd10);
         if (mdl_pop) begin
            void'(mdl_q.pop_front());
            mdl_words = mdl_words + 16'd1;
         end
         if (load_base) mdl_addr = base_addr;
         else if (mdl_pop) mdl_addr = mdl_addr + 32'd4;
         if (mdl_acc && (op <= 4'd10)) begin
            mdl_q.push_back(refEncode(op, rd, rn, rm, imm, hw));
            mdl_fresh = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      checkOutput("in_ready", 32'(in_ready), 32'(mdl_q.size() < 4));
      checkOutput("busy", 32'(busy), 32'(mdl_q.size() > 0));
      checkOutput("imem_we", 32'(imem_we), 32'(mdl_q.size() > 0));
      checkOutput("imem_addr", imem_addr, mdl_addr);
      checkOutput("words_written", 32'(words_written), 32'(mdl_words));
      checkOutput("err", 32'(err), 32'(mdl_err));
      if (mdl_q.size() > 0) checkOutput("imem_wdata", imem_wdata, mdl_q[0]);
      else if (mdl_fresh) checkOutput("imem_wdata_reset", imem_wdata, 32'h0);
   end

   initial begin
      int guard;
      reset = 1'b1;
      idle(1'b0);
      tick(2);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_wdata", imem_wdata, 32'h0);
      reset = 1'b0;

      // Single ADDREG write
      applyStimulus(1'b1, 4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("s1_we", 32'(imem_we), 32'd1);
      checkOutput("s1_addr", imem_addr, 32'h0);
      checkOutput("s1_wdata", imem_wdata, 32'h8B020023);
      idle(1'b1);
      tick(1);
      checkOutput("s1_words", 32'(words_written), 32'd1);

      // Back-to-back from a loaded base
      applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b1, 32'h100, 1'b1);
      tick(1);
      applyStimulus(1'b1, 4'd6, 5'd9, 5'd0, 5'd0, 26'hBEEF, 2'd2, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("s2_addr0", imem_addr, 32'h100);
      checkOutput("s2_wdata0", imem_wdata, 32'hD2D7DDE9);
      applyStimulus(1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 2'd0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("s2_addr1", imem_addr, 32'h104);
      checkOutput("s2_wdata1", imem_wdata, 32'h17FFFFFF);
      applyStimulus(1'b1, 4'd9, 5'd4, 5'd5, 5'd0, 26'h1FF, 2'd0, 1'b0, 32'h0, 1'b1);
      tick(1);
      checkOutput("s2_addr2", imem_addr, 32'h108);
      checkOutput("s2_wdata2", imem_wdata, 32'hF85FF0A4);
      idle(1'b1);
      tick(1);
      checkOutput("s2_words", 32'(words_written), 32'd4);

      // Backpressure: five requests into a stalled memory
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'd4, 5'(i), 5'd1, 5'd0, 26'(i), 2'd0, 1'b0, 32'h0, 1'b0);
         tick(1);
      end
      checkOutput("s3_full", 32'(in_ready), 32'd0);
      applyStimulus(1'b1, 4'd4, 5'd4, 5'd1, 5'd0, 26'd4, 2'd0, 1'b0, 32'h0, 1'b0);
      tick(3);
      checkOutput("s3_hold_addr", imem_addr, 32'h10C);
      checkOutput("s3_hold_wdata", imem_wdata, 32'h91000020);
      applyStimulus(1'b1, 4'd4, 5'd4, 5'd1, 5'd0, 26'd4, 2'd0, 1'b0, 32'h0, 1'b1);
      guard = 0;
      while (!in_ready && guard < 10) begin
         tick(1);
         guard++;
      end
      checkOutput("s3_ready_bound", 32'(guard < 10), 32'd1);
      tick(1);
      idle(1'b1);
      tick(6);
      checkOutput("s3_words", 32'(words_written), 32'd9);
      checkOutput("s3_addr", imem_addr, 32'h120);

      // Illegal op with three words queued
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                       26'd0, 2'd0, 1'b0, 32'h0, 1'b0);
         tick(1);
      end
      applyStimulus(1'b1, 4'd12, 5'd1, 5'd1, 5'd1, 26'd1, 2'd0, 1'b0, 32'h0, 1'b0);
      tick(1);
      checkOutput("s4_err", 32'(err), 32'd1);
      checkOutput("s4_count", 32'(in_ready), 32'd1);
      idle(1'b0);
      tick(1);
      checkOutput("s4_err_off", 32'(err), 32'd0);
      applyStimulus(1'b1, 4'd8, 5'd7, 5'd0, 5'd0, 26'h12345, 2'd0, 1'b0, 32'h0, 1'b0);
      tick(1);
      checkOutput("s4_full", 32'(in_ready), 32'd0);

      // load_base colliding with a completing write
      applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b1, 32'h0, 1'b0);
      tick(1);
      idle(1'b1);
      tick(2);
      checkOutput("s5_addr8", imem_addr, 32'h8);
      applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 1'b1, 32'hFFFFFFFC, 1'b1);
      tick(1);
      checkOutput("s5_base", imem_addr, 32'hFFFFFFFC);
      checkOutput("s5_words", 32'(words_written), 32'd12);
      idle(1'b1);
      tick(1);
      checkOutput("s5_wrap", imem_addr, 32'h0);
      checkOutput("s5_words2", 32'(words_written), 32'd13);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd7, 5'd0, 5'd0, 5'd0, 26'($urandom), 2'd0, 1'b0, 32'h0, 1'b0);
         tick(1);
      end
      idle(1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("s6_busy", 32'(busy), 32'd0);
      checkOutput("s6_we", 32'(imem_we), 32'd0);
      checkOutput("s6_addr", imem_addr, 32'h0);
      checkOutput("s6_words", 32'(words_written), 32'd0);
      checkOutput("s6_wdata", imem_wdata, 32'h0);
      applyStimulus(1'b1, 4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 1'b0, 32'h0, 1'b1);
      tick(2);
      reset = 1'b0;
      idle(1'b1);
      tick(1);
      checkOutput("s6_after", 32'(words_written), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom),
                       5'($urandom), 5'($urandom), 26'($urandom), 2'($urandom),
                       1'($urandom_range(0, 15) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
         tick(1);
      end
      idle(1'b1);
      tick(6);
      checkOutput("drain_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
